// File: rtl/rggen_axi4lite_bridge_timeout_pkg.sv
// Shared definitions for the rggen AXI4-Lite bridge: rggen bus codes, FSM states and helpers.
package rggen_axi4lite_bridge_timeout_pkg;

    localparam logic [1:0] RGGEN_READ         = 2'b10;
    localparam logic [1:0] RGGEN_OKAY         = 2'b00;
    localparam logic [1:0] RGGEN_EXOKAY       = 2'b01;
    localparam logic [1:0] RGGEN_SLAVE_ERROR  = 2'b10;
    localparam logic [1:0] RGGEN_DECODE_ERROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } bridge_state_e;

    // A zero-width ID collapses to a single tied-off bit.
    function automatic int unsigned id_w(input int unsigned width);
        return (width == 0) ? 1 : width;
    endfunction

    function automatic logic is_write(input logic [1:0] access);
        return access != RGGEN_READ;
    endfunction

endpackage

// File: rtl/rggen_bridge_timer.sv
// Request timeout counter: cleared on request latch, counts enabled cycles, flags expiry.
module rggen_bridge_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_c
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_c;
            assign unused_c = clear_i ^ enable_i ^ i_clk ^ i_rst_n;
            assign expire_c = 1'b0;
        end else begin : g_on
            localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
            logic [TW-1:0] count_q;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    count_q <= '0;
                end else if (clear_i) begin
                    count_q <= '0;
                end else if (enable_i && (count_q != TW'(TIMEOUT_CYCLES))) begin
                    count_q <= count_q + TW'(1);
                end
            end

            // Expires on the cycle that brings the count to TIMEOUT_CYCLES.
            assign expire_c = enable_i && !clear_i && (count_q == TW'(TIMEOUT_CYCLES - 1));
        end
    endgenerate

endmodule

// File: rtl/rggen_axi4lite_bridge_timeout.sv
// rggen register-bus to AXI4-Lite master bridge with request timeout and late-response drain.
module rggen_axi4lite_bridge_timeout
    import rggen_axi4lite_bridge_timeout_pkg::*;
#(
    parameter int unsigned ID_WIDTH       = 0,
    parameter int unsigned ID_VALUE       = 0,
    parameter int unsigned ADDRESS_WIDTH  = 8,
    parameter int unsigned BUS_WIDTH      = 32,
    parameter logic [2:0]  PROT           = 3'b000,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_bus_valid,
    input  logic [1:0]                    i_bus_access,
    input  logic [ADDRESS_WIDTH-1:0]      i_bus_address,
    input  logic [BUS_WIDTH-1:0]          i_bus_write_data,
    input  logic [BUS_WIDTH/8-1:0]        i_bus_strobe,
    output logic                          o_bus_ready,
    output logic [1:0]                    o_bus_status,
    output logic [BUS_WIDTH-1:0]          o_bus_read_data,
    output logic                          o_timeout,
    output logic                          o_awvalid,
    input  logic                          i_awready,
    output logic [id_w(ID_WIDTH)-1:0]     o_awid,
    output logic [ADDRESS_WIDTH-1:0]      o_awaddr,
    output logic [2:0]                    o_awprot,
    output logic                          o_wvalid,
    input  logic                          i_wready,
    output logic [BUS_WIDTH-1:0]          o_wdata,
    output logic [BUS_WIDTH/8-1:0]        o_wstrb,
    input  logic                          i_bvalid,
    output logic                          o_bready,
    input  logic [id_w(ID_WIDTH)-1:0]     i_bid,
    input  logic [1:0]                    i_bresp,
    output logic                          o_arvalid,
    input  logic                          i_arready,
    output logic [id_w(ID_WIDTH)-1:0]     o_arid,
    output logic [ADDRESS_WIDTH-1:0]      o_araddr,
    output logic [2:0]                    o_arprot,
    input  logic                          i_rvalid,
    output logic                          o_rready,
    input  logic [id_w(ID_WIDTH)-1:0]     i_rid,
    input  logic [1:0]                    i_rresp,
    input  logic [BUS_WIDTH-1:0]          i_rdata
);

    localparam int unsigned IDW = id_w(ID_WIDTH);
    localparam int unsigned SW  = BUS_WIDTH / 8;

    bridge_state_e            state_q, state_d;
    logic                     write_q, write_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [BUS_WIDTH-1:0]     wdata_q, wdata_d;
    logic [SW-1:0]            strb_q, strb_d;
    logic                     aw_done_q, aw_done_d;
    logic                     w_done_q, w_done_d;
    logic                     ar_done_q, ar_done_d;
    logic                     awvalid_q, awvalid_d;
    logic                     wvalid_q, wvalid_d;
    logic                     arvalid_q, arvalid_d;
    logic                     bready_q, bready_d;
    logic                     rready_q, rready_d;
    logic                     ready_q, ready_d;
    logic                     timeout_q, timeout_d;
    logic [1:0]               status_q, status_d;
    logic [BUS_WIDTH-1:0]     rdata_q, rdata_d;

    logic latch_c;
    logic expire_c;
    logic resp_hs_c;
    logic wait_resp_c;
    logic unused_id_c;

    assign unused_id_c = ^{i_bid, i_rid};
    assign latch_c     = (state_q == ST_IDLE) && i_bus_valid;
    assign resp_hs_c   = write_q ? (bready_q && i_bvalid) : (rready_q && i_rvalid);

    rggen_bridge_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .clear_i  (latch_c),
        .enable_i (state_q == ST_REQ),
        .expire_c (expire_c)
    );

    // Next-state, done tracking and registered AXI/bus output values.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        aw_done_d   = aw_done_q || (awvalid_q && i_awready);
        w_done_d    = w_done_q  || (wvalid_q  && i_wready);
        ar_done_d   = ar_done_q || (arvalid_q && i_arready);
        ready_d     = 1'b0;
        timeout_d   = 1'b0;
        status_d    = status_q;
        rdata_d     = rdata_q;
        wait_resp_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_bus_valid) begin
                    state_d   = ST_REQ;
                    write_d   = is_write(i_bus_access);
                    addr_d    = i_bus_address;
                    wdata_d   = i_bus_write_data;
                    strb_d    = i_bus_strobe;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    ar_done_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (resp_hs_c) begin
                    state_d  = ST_DONE;
                    ready_d  = 1'b1;
                    status_d = write_q ? i_bresp : i_rresp;
                    rdata_d  = write_q ? '0 : i_rdata;
                end else if (expire_c) begin
                    state_d   = ST_DONE;
                    ready_d   = 1'b1;
                    timeout_d = 1'b1;
                    status_d  = RGGEN_SLAVE_ERROR;
                    rdata_d   = '0;
                end
            end
            ST_DONE: begin
                state_d = timeout_q ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (resp_hs_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Valids hold through DONE/DRAIN until accepted; readies only while awaiting a response.
        wait_resp_c = (state_d == ST_REQ) || (state_d == ST_DRAIN);
        awvalid_d   = (state_d != ST_IDLE) && write_d  && !aw_done_d;
        wvalid_d    = (state_d != ST_IDLE) && write_d  && !w_done_d;
        arvalid_d   = (state_d != ST_IDLE) && !write_d && !ar_done_d;
        bready_d    = wait_resp_c && write_d  && aw_done_d && w_done_d;
        rready_d    = wait_resp_c && !write_d && ar_done_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ar_done_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            ready_q   <= 1'b0;
            timeout_q <= 1'b0;
            status_q  <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            ar_done_q <= ar_done_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
            ready_q   <= ready_d;
            timeout_q <= timeout_d;
            status_q  <= status_d;
            rdata_q   <= rdata_d;
        end
    end

    assign o_bus_ready     = ready_q;
    assign o_bus_status    = status_q;
    assign o_bus_read_data = rdata_q;
    assign o_timeout       = timeout_q;
    assign o_awvalid       = awvalid_q;
    assign o_awid          = IDW'(ID_VALUE);
    assign o_awaddr        = addr_q;
    assign o_awprot        = PROT;
    assign o_wvalid        = wvalid_q;
    assign o_wdata         = wdata_q;
    assign o_wstrb         = strb_q;
    assign o_bready        = bready_q;
    assign o_arvalid       = arvalid_q;
    assign o_arid          = IDW'(ID_VALUE);
    assign o_araddr        = addr_q;
    assign o_arprot        = PROT;
    assign o_rready        = rready_q;

endmodule

// File: tb/tb_rggen_axi4lite_bridge_timeout.sv
// Directed scoreboard bench for the rggen AXI4-Lite bridge (TIMEOUT_CYCLES = 8).
module tb_rggen_axi4lite_bridge_timeout;

    typedef struct packed {
        logic [1:0]  status;
        logic [31:0] data;
        logic        to;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_valid = 1'b0;
    logic [1:0]  bus_access = 2'b00;
    logic [7:0]  bus_address = '0;
    logic [31:0] bus_write_data = '0;
    logic [3:0]  bus_strobe = '0;
    logic        bus_ready;
    logic [1:0]  bus_status;
    logic [31:0] bus_read_data;
    logic        timeout;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [0:0]  awid, arid;
    logic [7:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = '0;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    rggen_axi4lite_bridge_timeout #(
        .ID_WIDTH(0), .ID_VALUE(0), .ADDRESS_WIDTH(8), .BUS_WIDTH(32),
        .PROT(3'b000), .TIMEOUT_CYCLES(8)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_bus_valid(bus_valid), .i_bus_access(bus_access), .i_bus_address(bus_address),
        .i_bus_write_data(bus_write_data), .i_bus_strobe(bus_strobe),
        .o_bus_ready(bus_ready), .o_bus_status(bus_status), .o_bus_read_data(bus_read_data),
        .o_timeout(timeout),
        .o_awvalid(awvalid), .i_awready(awready), .o_awid(awid), .o_awaddr(awaddr), .o_awprot(awprot),
        .o_wvalid(wvalid), .i_wready(wready), .o_wdata(wdata), .o_wstrb(wstrb),
        .i_bvalid(bvalid), .o_bready(bready), .i_bid(1'b0), .i_bresp(bresp),
        .o_arvalid(arvalid), .i_arready(arready), .o_arid(arid), .o_araddr(araddr), .o_arprot(arprot),
        .i_rvalid(rvalid), .o_rready(rready), .i_rid(1'b0), .i_rresp(rresp), .i_rdata(rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock; the host drops its request once it has seen the ready pulse.
    task automatic step();
        @(posedge clk);
        #1;
        if (bus_ready) bus_valid = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic request(input logic [1:0] acc, input logic [7:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
        bus_valid      = 1'b1;
        bus_access     = acc;
        bus_address    = addr;
        bus_write_data = data;
        bus_strobe     = strb;
    endtask

    task automatic expect_resp(input logic [1:0] st, input logic [31:0] d, input logic to);
        exp_t e;
        e.status = st;
        e.data   = d;
        e.to     = to;
        exp_q.push_back(e);
    endtask

    // Response monitor: every ready pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (rst_n) begin
            if (timeout && !bus_ready) check("timeout_without_ready", 1, 0);
            if (bus_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("resp_status", 64'(bus_status), 64'(e.status));
                    check("resp_data", 64'(bus_read_data), 64'(e.data));
                    check("resp_timeout", 64'(timeout), 64'(e.to));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_rready", rready, 0);
        check("rst_ready", bus_ready, 0);
        check("rst_status", bus_status, 0);
        check("rst_rdata", bus_read_data, 0);
        check("rst_awid", awid, 0);
        rst_n = 1'b1;
        step();

        // 1: plain write, AW/W accepted together, B two cycles later
        request(2'b01, 8'h10, 32'hDEAD_BEEF, 4'hF);
        expect_resp(2'b00, 32'h0, 1'b0);
        step();
        check("t1_awvalid", awvalid, 1);
        check("t1_wvalid", wvalid, 1);
        check("t1_awaddr", awaddr, 8'h10);
        check("t1_wdata", wdata, 32'hDEAD_BEEF);
        check("t1_wstrb", wstrb, 4'hF);
        check("t1_bready_early", bready, 0);
        awready = 1'b1; wready = 1'b1;
        step();
        awready = 1'b0; wready = 1'b0;
        check("t1_awvalid_drop", awvalid, 0);
        check("t1_bready", bready, 1);
        step();
        bvalid = 1'b1; bresp = 2'b00;
        step();
        bvalid = 1'b0;
        check("t1_ready", bus_ready, 1);
        step();
        check("t1_ready_pulse", bus_ready, 0);

        // 2: W accepted three cycles before AW
        request(2'b00, 8'h20, 32'hA5A5_0001, 4'b0011);
        expect_resp(2'b01, 32'h0, 1'b0);
        step();
        wready = 1'b1;
        step();
        wready = 1'b0;
        check("t2_wvalid_drop", wvalid, 0);
        check("t2_awvalid_hold", awvalid, 1);
        check("t2_bready_wait", bready, 0);
        steps(2);
        check("t2_bready_wait2", bready, 0);
        awready = 1'b1;
        step();
        awready = 1'b0;
        check("t2_awvalid_drop", awvalid, 0);
        check("t2_bready", bready, 1);
        bvalid = 1'b1; bresp = 2'b01;
        step();
        bvalid = 1'b0;
        step();

        // 3: read with AR accepted after two cycles, SLVERR response carrying data
        request(2'b10, 8'h24, 32'h0, 4'h0);
        expect_resp(2'b10, 32'h1234_5678, 1'b0);
        step();
        check("t3_arvalid", arvalid, 1);
        check("t3_araddr", araddr, 8'h24);
        check("t3_awvalid", awvalid, 0);
        check("t3_rready_early", rready, 0);
        steps(2);
        arready = 1'b1;
        step();
        arready = 1'b0;
        check("t3_arvalid_drop", arvalid, 0);
        check("t3_rready", rready, 1);
        rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b10;
        step();
        rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        step();

        // 4: read times out, late R is drained, a held request waits for IDLE
        request(2'b10, 8'h30, 32'h0, 4'h0);
        expect_resp(2'b10, 32'h0, 1'b1);
        step();
        arready = 1'b1;
        step();
        arready = 1'b0;
        steps(6);
        check("t4_no_ready_yet", bus_ready, 0);
        step();
        check("t4_ready", bus_ready, 1);
        check("t4_timeout", timeout, 1);
        step();
        check("t4_drain_rready", rready, 1);
        request(2'b01, 8'h40, 32'h0BAD_F00D, 4'hF);
        expect_resp(2'b00, 32'h0, 1'b0);
        step();
        check("t4_drain_no_latch", awvalid, 0);
        rvalid = 1'b1; rdata = 32'hFFFF_FFFF; rresp = 2'b00;
        step();
        rvalid = 1'b0; rdata = '0;
        check("t4_drained_rready", rready, 0);
        check("t4_drained_no_ready", bus_ready, 0);
        step();
        check("t4_next_awvalid", awvalid, 1);
        check("t4_next_awaddr", awaddr, 8'h40);
        awready = 1'b1; wready = 1'b1;
        step();
        awready = 1'b0; wready = 1'b0;
        bvalid = 1'b1; bresp = 2'b00;
        step();
        bvalid = 1'b0;
        step();

        // 5: B handshake on the expiry cycle wins
        request(2'b11, 8'h44, 32'h5555_AAAA, 4'hC);
        expect_resp(2'b11, 32'h0, 1'b0);
        step();
        awready = 1'b1; wready = 1'b1;
        step();
        awready = 1'b0; wready = 1'b0;
        steps(6);
        bvalid = 1'b1; bresp = 2'b11;
        step();
        bvalid = 1'b0; bresp = 2'b00;
        check("t5_ready", bus_ready, 1);
        check("t5_no_timeout", timeout, 0);
        step();

        // 6: reset in the middle of a write, then a fresh write
        request(2'b01, 8'h50, 32'h1111_2222, 4'hF);
        step();
        check("t6_awvalid_pre", awvalid, 1);
        bus_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("t6_rst_awvalid", awvalid, 0);
        check("t6_rst_wvalid", wvalid, 0);
        check("t6_rst_bready", bready, 0);
        check("t6_rst_ready", bus_ready, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        request(2'b01, 8'h54, 32'h3333_4444, 4'h1);
        expect_resp(2'b00, 32'h0, 1'b0);
        step();
        check("t6_awaddr", awaddr, 8'h54);
        awready = 1'b1; wready = 1'b1;
        step();
        awready = 1'b0; wready = 1'b0;
        bvalid = 1'b1; bresp = 2'b00;
        step();
        bvalid = 1'b0;
        steps(4);

        check("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
